// File: rtl/rx_mtr_pkg.sv
// Shared definitions for the RX meander tracker: FSM encoding and default geometry.
package rx_mtr_pkg;

  localparam int W_DEF    = 12;
  localparam int MW_DEF   = 4;
  localparam int MMAX_DEF = 10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACQ  = 2'd1,
    ST_UPD  = 2'd2
  } mtr_state_e;

endpackage

// File: rtl/rx_hyst_cmp.sv
// Hysteresis comparator: polarity=1 sets above set_th / clears below clr_th,
// polarity=0 sets below set_th / clears above clr_th.
module rx_hyst_cmp
  import rx_mtr_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic         clk,
  input  logic         res,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] x,
  input  logic [W-1:0] set_th,
  input  logic [W-1:0] clr_th,
  input  logic         polarity,
  output logic         q
);

  logic q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = 1'b0;
    end else if (en) begin
      if (polarity) begin
        if (x > set_th)      q_d = 1'b1;
        else if (x < clr_th) q_d = 1'b0;
      end else begin
        if (x < set_th)      q_d = 1'b1;
        else if (x > clr_th) q_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) q_q <= 1'b0;
    else      q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/rx_mtr_tracker.sv
// ADC receive-path tracker: windowed min/max, midpoint/amplitude/threshold
// derivation and RXP/RXN hysteresis slicing.
//
// state   | meaning
// IDLE    | waiting for st
// ACQ     | collecting 2^Mc valid samples into run_max/run_min
// UPD     | one cycle: publish results, pulse done, reload or stop
module rx_mtr_tracker
  import rx_mtr_pkg::*;
#(
  parameter int W    = W_DEF,
  parameter int MW   = MW_DEF,
  parameter int MMAX = MMAX_DEF
) (
  input  logic          clk,
  input  logic          res,
  input  logic          st,
  input  logic          clr,
  input  logic [MW-1:0] M,
  input  logic          S,
  input  logic [W-1:0]  din,
  input  logic          din_vld,
  output logic [W-1:0]  Xmax,
  output logic [W-1:0]  Xmin,
  output logic [W-1:0]  Xns,
  output logic [W-2:0]  AMP,
  output logic [W-1:0]  REF_P,
  output logic [W-1:0]  REF_N,
  output logic          RXP,
  output logic          RXN,
  output logic          busy,
  output logic          done
);

  localparam int CW = MMAX + 1;
  localparam int AW = W - 1;

  mtr_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, load_q, load_d;
  logic          s_q, s_d, first_q, first_d;
  logic [W-1:0]  run_max_q, run_max_d, run_min_q, run_min_d;
  logic [W-1:0]  xmax_q, xmax_d, xmin_q, xmin_d, xns_q, xns_d;
  logic [AW-1:0] amp_q, amp_d;
  logic [W-1:0]  refp_q, refp_d, refn_q, refn_d;
  logic          ref_ok_q, ref_ok_d, done_q, done_d, busy_q, busy_d;

  logic [MW-1:0] m_clamp;
  logic [CW-1:0] cnt_load;
  logic [W-1:0]  xns_c, amp_half;
  logic [AW-1:0] amp_c;

  always_comb begin
    m_clamp  = (M > MW'(MMAX)) ? MW'(MMAX) : M;
    cnt_load = CW'(1) << m_clamp;
    // sum carried at W+1 bits so the midpoint never wraps
    xns_c    = W'(({1'b0, run_max_q} + {1'b0, run_min_q}) >> 1);
    amp_c    = AW'((run_max_q - run_min_q) >> 1);
    amp_half = W'(amp_c >> 1);
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    load_d    = load_q;
    s_d       = s_q;
    first_d   = first_q;
    run_max_d = run_max_q;
    run_min_d = run_min_q;
    xmax_d    = xmax_q;
    xmin_d    = xmin_q;
    xns_d     = xns_q;
    amp_d     = amp_q;
    refp_d    = refp_q;
    refn_d    = refn_q;
    ref_ok_d  = ref_ok_q;
    done_d    = 1'b0;

    if (clr) begin
      state_d   = ST_IDLE;
      cnt_d     = '0;
      load_d    = '0;
      s_d       = 1'b0;
      first_d   = 1'b0;
      run_max_d = '0;
      run_min_d = '0;
      xmax_d    = '0;
      xmin_d    = '0;
      xns_d     = '0;
      amp_d     = '0;
      refp_d    = '0;
      refn_d    = '0;
      ref_ok_d  = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_ACQ: begin
          if (st) begin
            state_d = ST_ACQ;
            load_d  = cnt_load;
            cnt_d   = cnt_load;
            s_d     = S;
            first_d = 1'b1;
          end else if (state_q == ST_ACQ && din_vld) begin
            if (first_q) begin
              run_max_d = din;
              run_min_d = din;
              first_d   = 1'b0;
            end else begin
              if (din > run_max_q) run_max_d = din;
              if (din < run_min_q) run_min_d = din;
            end
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) state_d = ST_UPD;
          end
        end
        ST_UPD: begin
          xmax_d   = run_max_q;
          xmin_d   = run_min_q;
          xns_d    = xns_c;
          amp_d    = amp_c;
          refp_d   = xns_c + amp_half;
          refn_d   = xns_c - amp_half;
          done_d   = 1'b1;
          ref_ok_d = 1'b1;
          if (s_q) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_ACQ;
            cnt_d   = load_q;
            first_d = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      load_q    <= '0;
      s_q       <= 1'b0;
      first_q   <= 1'b0;
      run_max_q <= '0;
      run_min_q <= '0;
      xmax_q    <= '0;
      xmin_q    <= '0;
      xns_q     <= '0;
      amp_q     <= '0;
      refp_q    <= '0;
      refn_q    <= '0;
      ref_ok_q  <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      load_q    <= load_d;
      s_q       <= s_d;
      first_q   <= first_d;
      run_max_q <= run_max_d;
      run_min_q <= run_min_d;
      xmax_q    <= xmax_d;
      xmin_q    <= xmin_d;
      xns_q     <= xns_d;
      amp_q     <= amp_d;
      refp_q    <= refp_d;
      refn_q    <= refn_d;
      ref_ok_q  <= ref_ok_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
    end
  end

  rx_hyst_cmp #(.W(W)) u_cmp_p (
    .clk      (clk),
    .res      (res),
    .clr      (clr),
    .en       (din_vld & ref_ok_q),
    .x        (din),
    .set_th   (refp_q),
    .clr_th   (xns_q),
    .polarity (1'b1),
    .q        (RXP)
  );

  rx_hyst_cmp #(.W(W)) u_cmp_n (
    .clk      (clk),
    .res      (res),
    .clr      (clr),
    .en       (din_vld & ref_ok_q),
    .x        (din),
    .set_th   (refn_q),
    .clr_th   (xns_q),
    .polarity (1'b0),
    .q        (RXN)
  );

  assign Xmax  = xmax_q;
  assign Xmin  = xmin_q;
  assign Xns   = xns_q;
  assign AMP   = amp_q;
  assign REF_P = refp_q;
  assign REF_N = refn_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule
